dmi_access_ctrl: RTL and testbench
==================================

DMI_ACCESS_CTRL -- requirements
Module: dmi_access_ctrl

Interface
REQ-001 Parameter: AddrBits, default 7, DMI address width.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous active-low reset.
REQ-005 dmi_select  in  1  DMI register selected in the TAP IR.
REQ-006 capture  in  1  one-cycle capture-DR pulse.
REQ-007 update  in  1  one-cycle update-DR pulse.
REQ-008 update_dr  in  AddrBits+34  shifted DR value {addr, data[31:0], op[1:0]}, valid with update.
REQ-009 dmireset  in  1  one-cycle pulse: clear the sticky error.
REQ-010 dmihardreset  in  1  one-cycle pulse: abort and clear the controller.
REQ-011 dmi_req_o  out  AddrBits+34  {address_q, data_q, op}; op is 2'h2 in Write, otherwise 2'h1.
REQ-012 dmi_req_valid_o  out  1  request valid.
REQ-013 dmi_req_ready_i  in  1  Debug Module (DM) accepts the request.
REQ-014 dmi_resp_data_i  in  32  response data.
REQ-015 dmi_resp_resp_i  in  2  response code; 0 means OK.
REQ-016 dmi_resp_valid_i  in  1  response valid.
REQ-017 dmi_resp_ready_o  out  1  response ready.
REQ-018 capture_dr_o  out  AddrBits+34  {address_q, data_q, status}, loaded into the DR on capture.
REQ-019 dmistat_o  out  2  sticky error, reported in dtmcs.
REQ-020 dmi_rst_o  out  1  one-cycle reset pulse to the DM.

Function
REQ-021 FSM states: Idle, Read, WaitReadValid, Write, WaitWriteValid.
REQ-022 Idle, when update && dmi_select && error_q==NoError:
- op=1: latch addr; go to Read.
- op=2: latch addr and data; go to Write.
- op=0 or op=3: no operation; stay in Idle.
REQ-023 An update is ignored while error_q!=NoError.
REQ-024 Read/Write: dmi_req_valid_o=1; go to the matching Wait state in the cycle dmi_req_ready_i=1.
REQ-025 Request fields are stable while dmi_req_valid_o=1.
REQ-026 WaitReadValid, on dmi_resp_valid_i: data_q<=dmi_resp_data_i; go to Idle.
REQ-027 WaitWriteValid, on dmi_resp_valid_i: data_q is unchanged; go to Idle.
REQ-028 In either Wait state, a response with dmi_resp_resp_i!=0 sets error_q=OPFailed (2'h2).
REQ-029 dmi_resp_ready_o is 1 in every cycle after reset is released.
REQ-030 Minimum latency, update to Idle, is 3 cycles (ready and response each in their first possible cycle).
REQ-031 update && dmi_select while state!=Idle: the request is dropped and error_q<=Busy (2'h3).
REQ-032 capture && dmi_select while state!=Idle: error_q<=Busy.
REQ-033 Status field of capture_dr_o:
- Busy when state!=Idle or error_q==Busy;
- otherwise error_q.
REQ-034 capture_dr_o is combinational from registered state.
REQ-035 error_q is sticky; only dmireset, dmihardreset or reset clears it.
REQ-036 dmireset in the same cycle as a Busy or OPFailed event: the clear wins.
REQ-037 dmihardreset, one cycle:
- state<=Idle; error_q, address_q, data_q <= 0;
- dmi_req_valid_o drops the next cycle, even mid-handshake;
- dmi_rst_o=1 for exactly that next cycle.
REQ-038 dmihardreset takes priority over every other input in the same cycle.
REQ-039 A response arriving in Idle or Read/Write is ignored.

Reset
REQ-040 While reset=0:
- state=Idle; address_q, data_q, error_q = 0;
- dmi_req_valid_o=0, dmi_resp_ready_o=0, dmi_rst_o=0, dmistat_o=0.
REQ-041 Reset assertion mid-transaction aborts it immediately, asynchronously.

Structure
REQ-042 A shared debug package holds:
- dmi_error_e (NoError 0, ReservedError 1, OPFailed 2, Busy 3);
- the dtm_op constants (Nop 0, Read 1, Write 2);
- the FSM state enum.
REQ-043 The block is a single module with no sub-modules; registers use the codebase's async-reset flop.

Verification
REQ-044 Read: update op=1, addr=0x11; ready in cycle 1; response 0xDEADBEEF, resp 0 in cycle 2 -> Idle; capture_dr_o={0x11, 0xDEADBEEF, 0}.
REQ-045 Write: update op=2, addr=0x10, data=0x1; ready held low 4 cycles -> valid held with stable {0x10, 0x1, 2}; no error.
REQ-046 Busy: second update while in WaitReadValid -> dmistat_o=3; later updates ignored until dmireset, after which dmistat_o=0.
REQ-047 Fail: response resp=2 -> dmistat_o=2; capture status=2.
REQ-048 Hard reset: dmihardreset in Read -> valid drops next cycle, dmi_rst_o high one cycle, state Idle, capture_dr_o=0.
REQ-049 Async reset asserted in WaitWriteValid -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/dmi_access_ctrl_pkg.sv
// Shared debug-transport types: DMI error codes, DTM op encodings and the
// access-controller state enum.
package dmi_access_ctrl_pkg;

  typedef enum logic [1:0] {
    DmiNoError       = 2'h0,
    DmiReservedError = 2'h1,
    DmiOpFailed      = 2'h2,
    DmiBusy          = 2'h3
  } dmi_error_e;

  localparam logic [1:0] DtmNop   = 2'h0;
  localparam logic [1:0] DtmRead  = 2'h1;
  localparam logic [1:0] DtmWrite = 2'h2;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWaitReadValid,
    StWrite,
    StWaitWriteValid
  } dmi_state_e;

endpackage

// File: rtl/dmi_access_ctrl.sv
// DMI access controller: turns JTAG DR updates into Debug Module requests and
// reports the sticky DMI status back through the captured DR.
module dmi_access_ctrl #(
  parameter int unsigned AddrBits = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dmi_select,
  input  logic                  capture,
  input  logic                  update,
  input  logic [AddrBits+33:0]  update_dr,
  input  logic                  dmireset,
  input  logic                  dmihardreset,
  output logic [AddrBits+33:0]  dmi_req_o,
  output logic                  dmi_req_valid_o,
  input  logic                  dmi_req_ready_i,
  input  logic [31:0]           dmi_resp_data_i,
  input  logic [1:0]            dmi_resp_resp_i,
  input  logic                  dmi_resp_valid_i,
  output logic                  dmi_resp_ready_o,
  output logic [AddrBits+33:0]  capture_dr_o,
  output logic [1:0]            dmistat_o,
  output logic                  dmi_rst_o
);
  import dmi_access_ctrl_pkg::*;

  dmi_state_e            state_q, state_d;
  dmi_error_e            error_q, error_d;
  logic [AddrBits-1:0]   address_q, address_d;
  logic [31:0]           data_q, data_d;
  logic                  dmi_rst_q;

  logic [AddrBits-1:0]   upd_addr;
  logic [31:0]           upd_data;
  logic [1:0]            upd_op;
  logic [1:0]            status;

  assign upd_addr = update_dr[AddrBits+33:34];
  assign upd_data = update_dr[33:2];
  assign upd_op   = update_dr[1:0];

  always_comb begin
    state_d   = state_q;
    error_d   = error_q;
    address_d = address_q;
    data_d    = data_q;

    unique case (state_q)
      StIdle: begin
        if (update && dmi_select && (error_q == DmiNoError)) begin
          if (upd_op == DtmRead) begin
            address_d = upd_addr;
            state_d   = StRead;
          end else if (upd_op == DtmWrite) begin
            address_d = upd_addr;
            data_d    = upd_data;
            state_d   = StWrite;
          end
        end
      end
      StRead: begin
        if (dmi_req_ready_i) state_d = StWaitReadValid;
      end
      StWrite: begin
        if (dmi_req_ready_i) state_d = StWaitWriteValid;
      end
      StWaitReadValid: begin
        if (dmi_resp_valid_i) begin
          data_d  = dmi_resp_data_i;
          state_d = StIdle;
          if (dmi_resp_resp_i != 2'h0) error_d = DmiOpFailed;
        end
      end
      StWaitWriteValid: begin
        if (dmi_resp_valid_i) begin
          state_d = StIdle;
          if (dmi_resp_resp_i != 2'h0) error_d = DmiOpFailed;
        end
      end
      default: state_d = StIdle;
    endcase

    // Touching the DMI register while a transaction is in flight is a protocol violation.
    if ((state_q != StIdle) && dmi_select && (update || capture)) error_d = DmiBusy;

    if (dmireset) error_d = DmiNoError;

    if (dmihardreset) begin
      state_d   = StIdle;
      error_d   = DmiNoError;
      address_d = '0;
      data_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      error_q   <= DmiNoError;
      address_q <= '0;
      data_q    <= '0;
      dmi_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      error_q   <= error_d;
      address_q <= address_d;
      data_q    <= data_d;
      dmi_rst_q <= dmihardreset;
    end
  end

  // Any non-idle state, or a sticky Busy, is reported to the debugger as Busy.
  assign status = ((state_q != StIdle) || (error_q == DmiBusy)) ? DmiBusy : error_q;

  assign dmi_req_o        = {address_q, data_q, (state_q == StWrite) ? DtmWrite : DtmRead};
  assign dmi_req_valid_o  = (state_q == StRead) || (state_q == StWrite);
  assign dmi_resp_ready_o = reset;
  assign capture_dr_o     = {address_q, data_q, status};
  assign dmistat_o        = error_q;
  assign dmi_rst_o        = dmi_rst_q;

endmodule

// File: tb/tb_dmi_access_ctrl.sv
// Directed bench for dmi_access_ctrl: a transaction-level model is checked
// against the DUT every cycle, plus literal checks of the key scenarios.
module tb_dmi_access_ctrl;
  localparam int AW = 7;
  localparam int DW = AW + 34;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          dmi_select = 1'b0, capture = 1'b0, update = 1'b0;
  logic [DW-1:0] update_dr = '0;
  logic          dmireset = 1'b0, dmihardreset = 1'b0;
  logic [DW-1:0] dmi_req_o;
  logic          dmi_req_valid_o;
  logic          dmi_req_ready_i = 1'b0;
  logic [31:0]   dmi_resp_data_i = '0;
  logic [1:0]    dmi_resp_resp_i = '0;
  logic          dmi_resp_valid_i = 1'b0;
  logic          dmi_resp_ready_o;
  logic [DW-1:0] capture_dr_o;
  logic [1:0]    dmistat_o;
  logic          dmi_rst_o;

  int n_cmp = 0;
  int n_mis = 0;

  dmi_access_ctrl #(.AddrBits(AW)) dut (
    .clk(clk), .reset(reset), .dmi_select(dmi_select), .capture(capture),
    .update(update), .update_dr(update_dr), .dmireset(dmireset),
    .dmihardreset(dmihardreset), .dmi_req_o(dmi_req_o),
    .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
    .dmi_resp_data_i(dmi_resp_data_i), .dmi_resp_resp_i(dmi_resp_resp_i),
    .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o),
    .capture_dr_o(capture_dr_o), .dmistat_o(dmistat_o), .dmi_rst_o(dmi_rst_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 = no transaction, 1 = request offered, 2 = awaiting response.
  int         phase = 0;
  bit         m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic [1:0]  m_err = 2'd0;
  bit         m_rst = 1'b0;
  logic [1:0]  err_n;
  bit         busy_evt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase = 0; m_wr = 0; m_addr = '0; m_data = '0; m_err = 0; m_rst = 0;
    end else begin
      m_rst = dmihardreset;
      if (dmihardreset) begin
        phase = 0; m_err = 0; m_addr = '0; m_data = '0;
      end else begin
        err_n    = m_err;
        busy_evt = (phase != 0) && dmi_select && (update || capture);
        if (phase == 0) begin
          if (update && dmi_select && m_err == 0 &&
              (update_dr[1:0] == 2'd1 || update_dr[1:0] == 2'd2)) begin
            m_addr = update_dr[DW-1:34];
            m_wr   = (update_dr[1:0] == 2'd2);
            if (m_wr) m_data = update_dr[33:2];
            phase = 1;
          end
        end else if (phase == 1) begin
          if (dmi_req_ready_i) phase = 2;
        end else if (dmi_resp_valid_i) begin
          if (!m_wr) m_data = dmi_resp_data_i;
          if (dmi_resp_resp_i != 0) err_n = 2'd2;
          phase = 0;
        end
        if (busy_evt) err_n = 2'd3;
        if (dmireset) err_n = 2'd0;
        m_err = err_n;
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] e_op, e_stat;
    e_op   = (phase == 1 && m_wr) ? 2'd2 : 2'd1;
    e_stat = (phase != 0 || m_err == 2'd3) ? 2'd3 : m_err;
    chk("m_req",        64'(dmi_req_o),        64'({m_addr, m_data, e_op}));
    chk("m_valid",      64'(dmi_req_valid_o),  64'(phase == 1));
    chk("m_resp_ready", 64'(dmi_resp_ready_o), 64'(reset));
    chk("m_capture",    64'(capture_dr_o),     64'({m_addr, m_data, e_stat}));
    chk("m_dmistat",    64'(dmistat_o),        64'(m_err));
    chk("m_rst",        64'(dmi_rst_o),        64'(m_rst));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [AW-1:0] a, input logic [31:0] d, input logic [1:0] op);
    update_dr = {a, d, op};
    update    = 1'b1;
    tick();
    update    = 1'b0;
  endtask

  task automatic pulse_dmireset();
    dmireset = 1'b1;
    tick();
    dmireset = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d, input logic [1:0] r);
    dmi_resp_valid_i = 1'b1; dmi_resp_data_i = d; dmi_resp_resp_i = r;
    tick();
    dmi_resp_valid_i = 1'b0; dmi_resp_resp_i = 2'd0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_valid", 64'(dmi_req_valid_o), 64'd0);
    chk("rst_ready", 64'(dmi_resp_ready_o), 64'd0);
    chk("rst_stat",  64'(dmistat_o), 64'd0);
    reset = 1'b1;
    dmi_select = 1'b1;
    tick();
    chk("ready_after_rst", 64'(dmi_resp_ready_o), 64'd1);

    // Read with minimum latency
    do_update(7'h11, 32'h0, 2'd1);
    chk("read_valid", 64'(dmi_req_valid_o), 64'd1);
    dmi_req_ready_i = 1'b1; tick(); dmi_req_ready_i = 1'b0;
    respond(32'hDEADBEEF, 2'd0);
    chk("read_capture", 64'(capture_dr_o), 64'({7'h11, 32'hDEADBEEF, 2'd0}));
    $display("read  addr=11 capture=%h", capture_dr_o);

    // Nop is ignored
    do_update(7'h12, 32'h0, 2'd0);
    chk("nop_valid", 64'(dmi_req_valid_o), 64'd0);

    // Write with back-pressure
    do_update(7'h10, 32'h1, 2'd2);
    for (int i = 0; i < 4; i++) begin
      chk("write_hold", 64'(dmi_req_o), 64'({7'h10, 32'h1, 2'd2}));
      tick();
    end
    dmi_req_ready_i = 1'b1; tick(); dmi_req_ready_i = 1'b0;
    respond(32'hFFFF0000, 2'd0);
    chk("write_stat", 64'(dmistat_o), 64'd0);
    chk("write_data", 64'(capture_dr_o), 64'({7'h10, 32'h1, 2'd0}));
    $display("write addr=10 stat=%0d", dmistat_o);

    // Busy: update while waiting for a response
    do_update(7'h05, 32'h0, 2'd1);
    dmi_req_ready_i = 1'b1; tick(); dmi_req_ready_i = 1'b0;
    do_update(7'h06, 32'h0, 2'd1);
    chk("busy_stat", 64'(dmistat_o), 64'd3);
    respond(32'h12345678, 2'd0);
    do_update(7'h07, 32'h0, 2'd1);
    chk("busy_ignored", 64'(dmi_req_valid_o), 64'd0);
    chk("busy_capture", 64'(capture_dr_o), 64'({7'h05, 32'h12345678, 2'd3}));
    pulse_dmireset();
    chk("busy_cleared", 64'(dmistat_o), 64'd0);
    $display("busy  stat cleared=%0d", dmistat_o);

    // Failed operation
    do_update(7'h22, 32'h0, 2'd1);
    dmi_req_ready_i = 1'b1; tick(); dmi_req_ready_i = 1'b0;
    respond(32'hCAFEF00D, 2'd2);
    chk("fail_stat", 64'(dmistat_o), 64'd2);
    chk("fail_capture", 64'(capture_dr_o), 64'({7'h22, 32'hCAFEF00D, 2'd2}));
    $display("fail  stat=%0d", dmistat_o);
    pulse_dmireset();

    // dmireset wins over a simultaneous Busy event
    do_update(7'h33, 32'h0, 2'd1);
    update_dr = {7'h34, 32'h0, 2'd1};
    update = 1'b1; dmireset = 1'b1;
    tick();
    update = 1'b0; dmireset = 1'b0;
    chk("clear_wins", 64'(dmistat_o), 64'd0);
    dmi_req_ready_i = 1'b1; tick(); dmi_req_ready_i = 1'b0;
    respond(32'h0BADF00D, 2'd0);
    $display("clear-wins stat=%0d", dmistat_o);

    // Hard reset mid-handshake
    do_update(7'h44, 32'h0, 2'd1);
    dmihardreset = 1'b1; dmi_req_ready_i = 1'b1;
    tick();
    dmihardreset = 1'b0; dmi_req_ready_i = 1'b0;
    chk("hr_valid", 64'(dmi_req_valid_o), 64'd0);
    chk("hr_rst", 64'(dmi_rst_o), 64'd1);
    chk("hr_capture", 64'(capture_dr_o), 64'd0);
    tick();
    chk("hr_rst_pulse", 64'(dmi_rst_o), 64'd0);
    $display("hardreset capture=%h", capture_dr_o);

    // Capture while busy, then async reset in WaitWriteValid
    do_update(7'h55, 32'hA5, 2'd2);
    capture = 1'b1; tick(); capture = 1'b0;
    chk("cap_busy", 64'(dmistat_o), 64'd3);
    dmi_req_ready_i = 1'b1; tick(); dmi_req_ready_i = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_valid", 64'(dmi_req_valid_o), 64'd0);
    chk("async_stat", 64'(dmistat_o), 64'd0);
    chk("async_ready", 64'(dmi_resp_ready_o), 64'd0);
    chk("async_capture", 64'(capture_dr_o), 64'd0);
    chk("async_req", 64'(dmi_req_o), 64'({7'h0, 32'h0, 2'd1}));
    $display("async reset capture=%h", capture_dr_o);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("post_reset_valid", 64'(dmi_req_valid_o), 64'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
